// File: rtl/rv_fetch_pkg.sv
// Shared fetch types: word width, canonical NOP encoding, ring entry layout
// and a ceiling-log2 helper for sizing the ring pointers.
package rv_fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
    } fetch_entry_t;

    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit boundary: PC request in, memory request/response, decode output, flush.
// master = the fetch unit itself, slave = the surrounding PC/memory/decode logic.
interface instr_fetch_unit_if;
    import rv_fetch_pkg::*;

    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic            pc_ready;
    logic            mem_req_valid;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_req_ready;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;
    logic            flush;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_pc;
    logic [XLEN-1:0] inst_data;

    modport master (
        input  pc, pc_valid, mem_req_ready, mem_rsp_valid, mem_rsp_data, flush, inst_ready,
        output pc_ready, mem_req_valid, mem_req_addr, inst_valid, inst_pc, inst_data
    );

    modport slave (
        output pc, pc_valid, mem_req_ready, mem_rsp_valid, mem_rsp_data, flush, inst_ready,
        input  pc_ready, mem_req_valid, mem_req_addr, inst_valid, inst_pc, inst_data
    );

endinterface

// File: rtl/fetch_ring.sv
// In-order {pc, data} ring with alloc/fill/pop pointers; head visible one cycle after fill.
// Latency: fill -> head_vld next cycle. Backpressure: caller must not alloc past DEPTH.
module fetch_ring
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         alloc,
    input  logic [XLEN-1:0]              alloc_pc,
    input  logic                         fill,
    input  logic [XLEN-1:0]              fill_data,
    input  logic                         pop,
    output logic [log2_ceil(DEPTH):0]    alloc_cnt,
    output logic [log2_ceil(DEPTH):0]    pend_cnt,
    output logic                         head_vld,
    output fetch_entry_t                 head
);

    localparam int AW = log2_ceil(DEPTH);
    localparam int PW = AW + 1;

    // Extra MSB on each pointer separates a full ring from an empty one.
    logic [PW-1:0] wr, rsp, rd;
    fetch_entry_t  ring [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr  <= '0;
            rsp <= '0;
            rd  <= '0;
        end else if (clear) begin
            wr  <= '0;
            rsp <= '0;
            rd  <= '0;
        end else begin
            if (alloc) wr  <= wr  + PW'(1);
            if (fill)  rsp <= rsp + PW'(1);
            if (pop)   rd  <= rd  + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
        end else begin
            if (alloc) ring[wr[AW-1:0]].pc    <= alloc_pc;
            if (fill)  ring[rsp[AW-1:0]].data <= fill_data;
        end
    end

    assign alloc_cnt = wr - rd;
    assign pend_cnt  = wr - rsp;
    assign head_vld  = (rsp != rd);
    assign head      = ring[rd[AW-1:0]];

endmodule

// File: rtl/instr_fetch_unit.sv
// Issues in-order I-mem reads per PC, pairs responses with their PC, presents them to decode.
// Latency: response cycle M -> inst_valid in M+1. Backpressure: registered credit, stale drops hold credit.
module instr_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master bus
);

    localparam int PW = log2_ceil(DEPTH) + 1;

    logic [PW-1:0] alloc_cnt;
    logic [PW-1:0] pend_cnt;
    logic [PW-1:0] drop_cnt;
    logic          credit;
    logic          alloc;
    logic          fill;
    logic          drop;
    logic          pop;
    logic          head_vld;
    fetch_entry_t  head;

    // Credit uses registered counts only, so a same-cycle pop never frees a slot.
    assign credit = ({1'b0, alloc_cnt} + {1'b0, drop_cnt}) < (PW+1)'(DEPTH);

    assign bus.mem_req_valid = bus.pc_valid & credit & ~bus.flush & reset;
    assign bus.mem_req_addr  = {bus.pc[XLEN-1:2], 2'b00};
    assign bus.pc_ready      = bus.mem_req_valid & bus.mem_req_ready;

    assign alloc = bus.pc_ready;
    assign drop  = bus.mem_rsp_valid & (drop_cnt != '0);
    assign fill  = bus.mem_rsp_valid & (drop_cnt == '0) & ~bus.flush;
    assign pop   = head_vld & bus.inst_ready & ~bus.flush;

    fetch_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk       (clk),
        .reset     (reset),
        .clear     (bus.flush),
        .alloc     (alloc),
        .alloc_pc  (bus.pc),
        .fill      (fill),
        .fill_data (bus.mem_rsp_data),
        .pop       (pop),
        .alloc_cnt (alloc_cnt),
        .pend_cnt  (pend_cnt),
        .head_vld  (head_vld),
        .head      (head)
    );

    // On flush every in-flight read becomes a drop; a response landing in that cycle retires one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (bus.flush) begin
            drop_cnt <= drop_cnt + pend_cnt - PW'(bus.mem_rsp_valid);
        end else if (drop) begin
            drop_cnt <= drop_cnt - PW'(1);
        end
    end

    assign bus.inst_valid = head_vld;
    assign bus.inst_pc    = head.pc;
    assign bus.inst_data  = head.data;

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!reset)
        !(bus.mem_rsp_valid && (pend_cnt == '0) && (drop_cnt == '0)));

    a_drop_bound: assert property (@(posedge clk) disable iff (!reset)
        drop_cnt <= PW'(DEPTH));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench: stimulus pushes accepted fetches into an expected queue and a memory queue;
// a negedge monitor checks every presented/popped instruction against the queue head.
module tb_instr_fetch_unit;
    import rv_fetch_pkg::*;

    localparam int DEPTH = 2;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
        bit              filled;
    } exp_t;

    typedef struct {
        logic [XLEN-1:0] data;
        int              due;
        bit              stale;
    } mem_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat_min = 0;
    int lat_max = 0;
    int last_acc_cyc = 0;
    bit fill_prev = 0;
    bit flush_prev = 0;
    logic [XLEN-1:0] cur_pc = '0;
    exp_t exp_q[$];
    mem_t mem_q[$];
    logic [XLEN-1:0] data_q[$];
    logic [XLEN-1:0] popped_pc[$];
    int pop_cyc[$];

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: presented instruction must be the oldest live fetch whose response has landed.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic ev;
        if (reset) begin
            ev = (exp_q.size() > 0) && exp_q[0].filled;
            check("inst_valid", XLEN'(bus.inst_valid), XLEN'(ev));
            if (bus.inst_valid && bus.inst_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got pc %h, expected no instruction", bus.inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("inst_pc", bus.inst_pc, e.pc);
                    check("inst_data", bus.inst_data, e.data);
                end
                popped_pc.push_back(bus.inst_pc);
                pop_cyc.push_back(cyc);
            end
        end
    end

    // One clock of stimulus plus the request-side checks for that cycle.
    task automatic step(input bit pv, input bit fl, input bit ird, input bit mrdy, input bit rsp_ok);
        int occ;
        int stale_cnt;
        bit exp_acc;
        bit done;
        mem_t m;
        logic [XLEN-1:0] d;
        @(posedge clk);
        cyc++;
        #1;
        if (flush_prev) begin
            exp_q.delete();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        end else if (fill_prev) begin
            done = 1'b0;
            foreach (exp_q[i]) if (!done && !exp_q[i].filled) begin
                exp_q[i].filled = 1'b1;
                done = 1'b1;
            end
        end
        flush_prev = fl;
        fill_prev  = 1'b0;
        stale_cnt = 0;
        foreach (mem_q[i]) if (mem_q[i].stale) stale_cnt++;
        occ = exp_q.size() + stale_cnt;
        check("drop_cnt", XLEN'(dut.drop_cnt), XLEN'(stale_cnt));

        bus.pc_valid      = pv;
        bus.pc            = cur_pc;
        bus.flush         = fl;
        bus.inst_ready    = ird & ~fl;
        bus.mem_req_ready = mrdy;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = RV_NOP;
        if (rsp_ok && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            m = mem_q.pop_front();
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = m.data;
            fill_prev = !m.stale && !fl;
        end
        exp_acc = pv && mrdy && !fl && (occ < DEPTH);
        #3;
        check("pc_ready", XLEN'(bus.pc_ready), XLEN'(exp_acc));
        check("mem_req_valid", XLEN'(bus.mem_req_valid), XLEN'(pv && !fl && (occ < DEPTH)));
        if (bus.mem_req_valid) check("mem_req_addr", bus.mem_req_addr, {cur_pc[XLEN-1:2], 2'b00});
        if (exp_acc) begin
            if (data_q.size() > 0) d = data_q.pop_front();
            else d = $urandom;
            exp_q.push_back('{pc: cur_pc, data: d, filled: 1'b0});
            mem_q.push_back('{data: d, due: cyc + 1 + int'($urandom_range(lat_max, lat_min)), stale: 1'b0});
            last_acc_cyc = cyc;
            cur_pc += 4;
        end
    endtask

    task automatic drain(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic set_lat(input int lo, input int hi);
        lat_min = lo;
        lat_max = hi;
    endtask

    initial begin : main
        bit fl;
        bus.pc_valid      = 1'b0;
        bus.pc            = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.flush         = 1'b0;
        bus.inst_ready    = 1'b0;
        #2;
        check("rst_inst_valid", XLEN'(bus.inst_valid), '0);
        check("rst_inst_pc", bus.inst_pc, '0);
        check("rst_inst_data", bus.inst_data, '0);
        check("rst_mem_req_valid", XLEN'(bus.mem_req_valid), '0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Idle after release.
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("idle_inst_valid", XLEN'(bus.inst_valid), '0);
        check("idle_inst_pc", bus.inst_pc, '0);

        // Three fetches through a one-cycle memory.
        set_lat(0, 0);
        cur_pc = '0;
        data_q = '{32'h00500093, 32'h00600113, 32'h002081B3};
        popped_pc.delete();
        for (int k = 0; k < 16 && popped_pc.size() < 3; k++) step(cur_pc < 12, 1'b0, 1'b1, 1'b1, 1'b1);
        settle();
        check("seq_pop_count", XLEN'(popped_pc.size()), 3);
        if (popped_pc.size() == 3)
            for (int i = 0; i < 3; i++) check("seq_pop_pc", popped_pc[i], XLEN'(i * 4));

        // Full ring blocks the third request until decode pops.
        drain(4);
        cur_pc = '0;
        popped_pc.delete();
        pop_cyc.delete();
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("full_accepts", cur_pc, 8);
        for (int k = 0; k < 10 && cur_pc != 12; k++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        settle();
        check("full_reaccept_gap", XLEN'(last_acc_cyc - ((pop_cyc.size() > 0) ? pop_cyc[0] : 0)), 1);
        drain(6);

        // Flush with two fetches in flight; redirect target comes out first.
        set_lat(3, 3);
        cur_pc = 'h10;
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("flush_inflight", cur_pc, 'h18);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        popped_pc.delete();
        set_lat(0, 0);
        cur_pc = 'h100;
        for (int k = 0; k < 20 && cur_pc == 'h100; k++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        drain(6);
        settle();
        check("flush_pop_count", XLEN'(popped_pc.size()), 1);
        check("flush_first_pc", (popped_pc.size() > 0) ? popped_pc[0] : '1, 'h100);

        // Flush in the same cycle as a response.
        set_lat(1, 1);
        cur_pc = 'h40;
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        popped_pc.delete();
        set_lat(0, 0);
        cur_pc = 'h200;
        for (int k = 0; k < 20 && cur_pc == 'h200; k++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        drain(6);
        settle();
        check("rspflush_pop_count", XLEN'(popped_pc.size()), 1);
        check("rspflush_first_pc", (popped_pc.size() > 0) ? popped_pc[0] : '1, 'h200);

        // Randomized traffic with flushes and redirects.
        set_lat(0, 3);
        cur_pc = 'h1000;
        for (int k = 0; k < 2000; k++) begin
            fl = ($urandom_range(99) < 3);
            step($urandom_range(99) < 80, fl, $urandom_range(99) < 70,
                 $urandom_range(99) < 75, $urandom_range(99) < 80);
            if (fl) cur_pc = $urandom;
        end
        drain(30);
        settle();
        check("rnd_drained", XLEN'(exp_q.size()), '0);

        // Asynchronous reset while an instruction is presented.
        set_lat(0, 1);
        cur_pc = 'h300;
        for (int k = 0; k < 30 && !bus.inst_valid; k++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("areset_precond", XLEN'(bus.inst_valid), 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("areset_inst_valid", XLEN'(bus.inst_valid), '0);
        check("areset_inst_pc", bus.inst_pc, '0);
        check("areset_inst_data", bus.inst_data, '0);
        check("areset_mem_req_valid", XLEN'(bus.mem_req_valid), '0);
        check("areset_pc_ready", XLEN'(bus.pc_ready), '0);
        exp_q.delete();
        mem_q.delete();
        fill_prev  = 1'b0;
        flush_prev = 1'b0;
        bus.pc_valid      = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.inst_ready    = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        popped_pc.delete();
        set_lat(0, 0);
        cur_pc = '0;
        for (int k = 0; k < 10 && cur_pc == 0; k++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        drain(5);
        settle();
        check("restart_pop_count", XLEN'(popped_pc.size()), 1);
        check("restart_first_pc", (popped_pc.size() > 0) ? popped_pc[0] : '1, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded its time limit, got cycle %0d, expected completion", cyc);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
